// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and shared-memory signals around mem_arbiter.
// The master modport is the arbiter's view; slave is the requesters' and memory's view.
interface mem_arbiter_if;
  logic        inst_ce;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_valid;

  logic        data_ce;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_valid;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        stall_req;
  logic        timeout_err;

  modport master (
    input  inst_ce, inst_addr,
    input  data_ce, data_we, data_addr, data_wdata,
    input  mem_rdata, mem_ready,
    output inst_rdata, inst_valid,
    output data_rdata, data_valid,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output stall_req, timeout_err
  );

  modport slave (
    output inst_ce, inst_addr,
    output data_ce, data_we, data_addr, data_wdata,
    output mem_rdata, mem_ready,
    input  inst_rdata, inst_valid,
    input  data_rdata, data_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  stall_req, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and load/store.
// Grant->valid is 3 cycles minimum; requesters hold ce (stall_req) until their valid pulse.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_BUSY = 2'd1,
    DATA_BUSY = 2'd2
  } state_t;

  localparam logic       GNT_INST    = 1'b0;
  localparam logic       GNT_DATA    = 1'b1;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        inst_valid_q, inst_valid_d;
  logic        data_valid_q, data_valid_d;
  logic        timeout_q, timeout_d;
  logic        pick_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_q       <= GNT_INST;
      wait_cnt_q   <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_valid_q <= inst_valid_d;
      data_valid_q <= data_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    wait_cnt_d   = wait_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_valid_d = 1'b0;
    data_valid_d = 1'b0;
    timeout_d    = timeout_q;
    pick_data    = bus.data_ce && (!bus.inst_ce || last_q == GNT_INST);

    case (state_q)
      IDLE: begin
        // The valid-pulse cycle never grants: the finishing requester still shows ce there.
        if (!inst_valid_q && !data_valid_q) begin
          if (pick_data) begin
            state_d     = DATA_BUSY;
            wait_cnt_d  = 8'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.data_we;
            mem_addr_d  = bus.data_addr;
            mem_wdata_d = bus.data_wdata;
          end else if (bus.inst_ce) begin
            state_d     = INST_BUSY;
            wait_cnt_d  = 8'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.inst_addr;
          end
        end
      end

      INST_BUSY, DATA_BUSY: begin
        if (bus.mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == INST_BUSY) begin
            inst_valid_d = 1'b1;
            inst_rdata_d = bus.mem_rdata;
            last_d       = GNT_INST;
          end else begin
            data_valid_d = 1'b1;
            if (!mem_we_q) data_rdata_d = bus.mem_rdata;
            last_d       = GNT_DATA;
          end
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          // Abort: owner still gets its pulse so the pipeline unstalls, with zeroed data.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          timeout_d = 1'b1;
          if (state_q == INST_BUSY) begin
            inst_valid_d = 1'b1;
            inst_rdata_d = 32'd0;
            last_d       = GNT_INST;
          end else begin
            data_valid_d = 1'b1;
            data_rdata_d = 32'd0;
            last_d       = GNT_DATA;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.inst_rdata  = inst_rdata_q;
  assign bus.data_rdata  = data_rdata_q;
  assign bus.inst_valid  = inst_valid_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.timeout_err = timeout_q;
  assign bus.stall_req   = (bus.inst_ce & ~inst_valid_q) | (bus.data_ce & ~data_valid_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected completions, a monitor pops them.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   mem_delay  = 1;
  bit   ready_idle = 0;
  int   wcnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic wait_pulses(input int n, input int budget, input string name, output int cyc);
    int seen;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.inst_valid === 1'b1) seen++;
      if (bus.data_valid === 1'b1) seen++;
    end
    if (seen < n) begin
      total++;
      bad++;
      $display("FAIL %s: saw %0d valid pulses, expected %0d within %0d cycles", name, seen, n, budget);
    end
  endtask

  // Memory model: answers after mem_delay cycles of mem_req.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        wcnt++;
        bus.mem_ready = (wcnt >= mem_delay);
        bus.mem_rdata = bus.mem_ready ? mem_word(bus.mem_addr) : 32'hBAD0_BAD0;
      end else begin
        wcnt = 0;
        bus.mem_ready = ready_idle;
        bus.mem_rdata = 32'hFFFF_FFFF;
      end
    end
  end

  // Monitor: every valid pulse must match the oldest expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.inst_valid === 1'b1 || bus.data_valid === 1'b1) begin
        total++;
        if (bus.inst_valid === 1'b1 && bus.data_valid === 1'b1) begin
          bad++;
          $display("FAIL both_valid: inst_valid and data_valid together at %0t", $time);
        end else if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid: inst_valid=%b data_valid=%b at %0t with nothing pending",
                   bus.inst_valid, bus.data_valid, $time);
        end else begin
          e = exp_q.pop_front();
          if (bus.data_valid !== e.is_data) begin
            bad++;
            $display("FAIL owner: data_valid=%b expected owner is_data=%b at %0t",
                     bus.data_valid, e.is_data, $time);
          end
          check32(e.is_data ? "data_rdata" : "inst_rdata",
                  e.is_data ? bus.data_rdata : bus.inst_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    int cyc;
    rst            = 1'b1;
    bus.inst_ce    = 1'b0;
    bus.inst_addr  = 32'd0;
    bus.data_ce    = 1'b0;
    bus.data_we    = 1'b0;
    bus.data_addr  = 32'd0;
    bus.data_wdata = 32'd0;
    #1 rst = 1'b0;
    #2;
    check32("rst_mem_req", bus.mem_req, 0);
    check32("rst_mem_we", bus.mem_we, 0);
    check32("rst_mem_addr", bus.mem_addr, 0);
    check32("rst_mem_wdata", bus.mem_wdata, 0);
    check32("rst_inst_valid", bus.inst_valid, 0);
    check32("rst_data_valid", bus.data_valid, 0);
    check32("rst_inst_rdata", bus.inst_rdata, 0);
    check32("rst_data_rdata", bus.data_rdata, 0);
    check32("rst_timeout_err", bus.timeout_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Fetch with memory answering two cycles after grant
    mem_delay     = 2;
    bus.inst_addr = 32'h100;
    bus.inst_ce   = 1'b1;
    exp_q.push_back('{1'b0, 32'h0050_0093});
    @(negedge clk);
    check32("fetch_busy_req", bus.mem_req, 1);
    check32("fetch_busy_addr", bus.mem_addr, 32'h100);
    check32("fetch_busy_we", bus.mem_we, 0);
    check32("fetch_busy_stall", bus.stall_req, 1);
    wait_pulses(1, 20, "fetch", cyc);
    check32("fetch_latency", 32'(cyc), 2);
    check32("fetch_pulse_stall", bus.stall_req, 0);
    check32("fetch_pulse_req", bus.mem_req, 0);
    bus.inst_ce = 1'b0;

    // mem_ready while idle must not produce anything
    ready_idle = 1'b1;
    repeat (4) @(negedge clk);
    ready_idle = 1'b0;
    check32("idle_ready_req", bus.mem_req, 0);

    // Conflict straight after reset: data, inst, data
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem_delay     = 1;
    bus.inst_addr = 32'h80;
    bus.data_addr = 32'h40;
    bus.data_we   = 1'b0;
    bus.inst_ce   = 1'b1;
    bus.data_ce   = 1'b1;
    exp_q.push_back('{1'b1, 32'h5A5A_0040});
    exp_q.push_back('{1'b0, 32'h5A5A_0080});
    exp_q.push_back('{1'b1, 32'h5A5A_0040});
    wait_pulses(3, 40, "conflict", cyc);
    bus.inst_ce = 1'b0;
    bus.data_ce = 1'b0;
    @(negedge clk);

    // Store: bus stays stable, data_rdata keeps the last load value
    mem_delay      = 3;
    bus.data_we    = 1'b1;
    bus.data_addr  = 32'h200;
    bus.data_wdata = 32'hDEAD_BEEF;
    bus.data_ce    = 1'b1;
    exp_q.push_back('{1'b1, 32'h5A5A_0040});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("store_req", bus.mem_req, 1);
      check32("store_we", bus.mem_we, 1);
      check32("store_addr", bus.mem_addr, 32'h200);
      check32("store_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    end
    wait_pulses(1, 10, "store", cyc);
    bus.data_ce = 1'b0;
    bus.data_we = 1'b0;
    @(negedge clk);

    // mem_ready arriving exactly at the timeout count completes normally
    mem_delay     = 5;
    bus.data_addr = 32'h44;
    bus.data_ce   = 1'b1;
    exp_q.push_back('{1'b1, 32'h5A5A_0044});
    wait_pulses(1, 20, "ready_at_timeout", cyc);
    check32("ready_at_timeout_latency", 32'(cyc), 6);
    check32("ready_at_timeout_err", bus.timeout_err, 0);
    bus.data_ce = 1'b0;
    @(negedge clk);

    // Timeout: memory never answers
    mem_delay     = 1000;
    bus.inst_addr = 32'h300;
    bus.inst_ce   = 1'b1;
    exp_q.push_back('{1'b0, 32'h0});
    wait_pulses(1, 20, "timeout", cyc);
    check32("timeout_latency", 32'(cyc), 6);
    check32("timeout_req", bus.mem_req, 0);
    check32("timeout_err_set", bus.timeout_err, 1);
    bus.inst_ce = 1'b0;
    repeat (3) @(negedge clk);
    check32("timeout_err_sticky", bus.timeout_err, 1);

    // A normal load afterwards leaves last grant on data
    mem_delay     = 1;
    bus.data_addr = 32'h48;
    bus.data_ce   = 1'b1;
    exp_q.push_back('{1'b1, 32'h5A5A_0048});
    wait_pulses(1, 10, "load_after_timeout", cyc);
    check32("timeout_err_after_load", bus.timeout_err, 1);
    bus.data_ce = 1'b0;
    @(negedge clk);

    // Reset in the middle of a data transaction
    mem_delay     = 1000;
    bus.data_addr = 32'h4C;
    bus.data_ce   = 1'b1;
    repeat (2) @(negedge clk);
    check32("pre_reset_req", bus.mem_req, 1);
    #2 rst = 1'b0;
    #1;
    check32("async_rst_req", bus.mem_req, 0);
    check32("async_rst_addr", bus.mem_addr, 0);
    check32("async_rst_timeout_err", bus.timeout_err, 0);
    check32("async_rst_data_valid", bus.data_valid, 0);
    bus.data_ce = 1'b0;
    repeat (3) @(negedge clk);
    mem_delay     = 1;
    bus.inst_addr = 32'h84;
    bus.data_addr = 32'h50;
    bus.inst_ce   = 1'b1;
    bus.data_ce   = 1'b1;
    rst = 1'b1;
    #1;
    check32("no_grant_before_edge", bus.mem_req, 0);
    exp_q.push_back('{1'b1, 32'h5A5A_0050});
    exp_q.push_back('{1'b0, 32'h5A5A_0084});
    wait_pulses(2, 20, "post_reset_conflict", cyc);
    bus.inst_ce = 1'b0;
    bus.data_ce = 1'b0;

    repeat (4) @(negedge clk);
    check32("pending_left", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, the maximum number of cycles a transaction waits for mem_ready before abort.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-low.
- inst_ce  in  1  fetch request, level, held until inst_valid.
- inst_addr  in  32  fetch address.
- inst_rdata  out  32  fetched word, registered.
- inst_valid  out  1  one-cycle fetch-completion pulse.
- data_ce  in  1  load/store request, level, held until data_valid.
- data_we  in  1  1 = store, 0 = load.
- data_addr  in  32  data address.
- data_wdata  in  32  store data.
- data_rdata  out  32  load word, registered.
- data_valid  out  1  one-cycle data-completion pulse.
- mem_req  out  1  shared single-port memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion, sampled on clk.
- stall_req  out  1  pipeline stall request to the stall controller.
- timeout_err  out  1  sticky abort flag.

Function
REQ-003 The FSM SHALL have the states IDLE, INST_BUSY and DATA_BUSY, and every output except stall_req SHALL be registered.
REQ-004 In IDLE with only data_ce high, the FSM SHALL go to DATA_BUSY and latch data_addr, data_we and data_wdata onto the mem_* outputs with mem_req=1.
REQ-005 In IDLE with only inst_ce high, the FSM SHALL go to INST_BUSY with mem_req=1, mem_we=0 and mem_addr=inst_addr.
REQ-006 In IDLE with both inst_ce and data_ce high, the FSM SHALL grant the requester not served last, using a 1-bit last-grant register that reset initialises to "inst", so data wins first.
REQ-007 While in a BUSY state, mem_req, mem_we, mem_addr and mem_wdata SHALL hold stable until mem_ready is sampled 1.
REQ-008 When mem_ready=1 in a BUSY state, the next cycle SHALL pulse the owner's valid output for exactly one cycle.
- On a load or fetch, the owner's rdata register SHALL also load mem_rdata.
- In the same transition, mem_req SHALL drop to 0, last-grant SHALL be updated and the FSM SHALL return to IDLE.
REQ-009 On a store completion, data_rdata SHALL keep its previous value.
REQ-010 Each grant SHALL be followed by at least one IDLE cycle, so the minimum transaction is 3 cycles from grant to valid when mem_ready is already 1.
REQ-011 An 8-bit wait counter SHALL clear on entry to a BUSY state and increment each BUSY cycle with mem_ready=0.
REQ-012 When the wait counter equals TIMEOUT, the FSM SHALL abort the transaction.
- mem_req drops, the owner's valid pulses with its rdata set to 0, timeout_err is set and the FSM returns to IDLE.
- timeout_err SHALL stay set until reset.
REQ-013 When mem_ready and the timeout condition occur in the same cycle, mem_ready SHALL take precedence and the transaction SHALL complete normally.
REQ-014 If the owner drops its ce mid-transaction, the memory transaction SHALL still complete and the valid pulse SHALL still be issued.
REQ-015 stall_req SHALL be combinational: (inst_ce & ~inst_valid) | (data_ce & ~data_valid).
REQ-016 mem_ready sampled in IDLE SHALL be ignored.

Reset
REQ-017 While rst=0, the block SHALL immediately and asynchronously force the following values:
- FSM=IDLE and last-grant=inst.
- mem_req=0, mem_we=0, mem_addr=0 and mem_wdata=0.
- inst_valid=0, data_valid=0, inst_rdata=0 and data_rdata=0.
- wait counter=0 and timeout_err=0.
REQ-018 Reset asserted mid-transaction SHALL abandon that transaction with no valid pulse, and after rst rises no request SHALL be granted before the first rising clk edge.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Fetch: inst_ce=1, inst_addr=0x100, mem_ready=1 two cycles after grant with mem_rdata=0x00500093 -> inst_rdata=0x00500093, one inst_valid pulse, stall_req=0 in the pulse cycle.
- Conflict: inst_ce and data_ce raised in the same cycle after reset, mem_ready=1 always -> data served first, then inst, then data again if both remain asserted.
- Store: data_ce=1, data_we=1, data_addr=0x200, data_wdata=0xDEADBEEF -> mem_we=1 with address and data stable until mem_ready, data_rdata unchanged.
- Timeout: TIMEOUT=4, mem_ready held 0 -> abort after 4 wait cycles, valid pulse with rdata=0, timeout_err=1 persisting.
- Reset mid-transaction: rst=0 while in DATA_BUSY -> mem_req=0 without waiting for clk, no data_valid, first grant after rst rises goes to data.
